// File: rtl/track_pkg.sv
// track_pkg: shared types and constants for the line-tracking controller.
//   state_t   : steering FSM state encoding (also driven onto the debug LEDs)
//   MODE_*    : motor-block mode codes
//   PAT_*     : filtered sensor patterns {left, mid, right}, 1 = line seen
//   pat_t     : decoded pattern class (direction hit, no line, or ambiguous)
package track_pkg;

   typedef enum logic [2:0] {
      STOP  = 3'd0,
      FWD   = 3'd1,
      LEFT  = 3'd2,
      RIGHT = 3'd3,
      LOST  = 3'd4
   } state_t;

   localparam logic [1:0] MODE_STOP  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_FWD   = 2'b11;

   localparam logic [2:0] PAT_NONE       = 3'b000;
   localparam logic [2:0] PAT_HARD_RIGHT = 3'b001;
   localparam logic [2:0] PAT_FWD        = 3'b010;
   localparam logic [2:0] PAT_RIGHT      = 3'b011;
   localparam logic [2:0] PAT_HARD_LEFT  = 3'b100;
   localparam logic [2:0] PAT_AMBIG      = 3'b101;
   localparam logic [2:0] PAT_LEFT       = 3'b110;
   localparam logic [2:0] PAT_ALL        = 3'b111;

   // hit=1: dir is a steering target; none=1: no line; neither: ambiguous
   typedef struct packed {
      logic   hit;
      logic   none;
      state_t dir;
   } pat_t;

   function automatic pat_t decode_pat(input logic [2:0] p);
      pat_t d;
      d = '{hit: 1'b0, none: 1'b0, dir: STOP};
      case (p)
         PAT_FWD, PAT_ALL:             d = '{hit: 1'b1, none: 1'b0, dir: FWD};
         PAT_LEFT, PAT_HARD_LEFT:      d = '{hit: 1'b1, none: 1'b0, dir: LEFT};
         PAT_RIGHT, PAT_HARD_RIGHT:    d = '{hit: 1'b1, none: 1'b0, dir: RIGHT};
         PAT_NONE:                     d = '{hit: 1'b0, none: 1'b1, dir: STOP};
         default:                      d = '{hit: 1'b0, none: 1'b0, dir: STOP};
      endcase
      return d;
   endfunction

   function automatic logic [1:0] mode_of(input state_t s);
      case (s)
         FWD:     return MODE_FWD;
         LEFT:    return MODE_LEFT;
         RIGHT:   return MODE_RIGHT;
         default: return MODE_STOP;
      endcase
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer plus stability filter.
//   clk, rst : clock, synchronous active-high reset
//   din      : asynchronous raw inputs
//   filt     : pattern that has been stable for DEB_CYCLES synchronized samples
module sensor_debounce #(
   parameter int WIDTH      = 3,
   parameter int DEB_CYCLES = 100_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] filt
);
   import track_pkg::*;

   localparam int CW = $clog2(DEB_CYCLES) + 1;
   localparam logic [CW-1:0] LOAD_AT = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] s1, s2, s2_prev;
   logic [CW-1:0]    deb_cnt, deb_cnt_nxt;

   always_comb begin
      deb_cnt_nxt = deb_cnt;
      if (s2 != s2_prev)
         deb_cnt_nxt = '0;
      else if (deb_cnt != CNT_MAX)
         deb_cnt_nxt = deb_cnt + CW'(1);
   end

   // Loading on the edge where the count becomes DEB_CYCLES-1 keeps the
   // filter delay at exactly DEB_CYCLES clocks. CNT_MAX exceeds LOAD_AT, so
   // a saturated counter never reloads.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         s2_prev <= '0;
         deb_cnt <= '0;
         filt    <= '0;
      end else begin
         s1      <= din;
         s2      <= s1;
         s2_prev <= s2;
         deb_cnt <= deb_cnt_nxt;
         if (deb_cnt_nxt == LOAD_AT)
            filt <= s2;
      end
   end

endmodule

// File: rtl/track_ctrl.sv
// track_ctrl: line-tracking steering stage.
//   clk, rst : 100 MHz clock, synchronous active-high reset
//   en       : run enable, 0 forces STOP immediately
//   sensor   : raw IR inputs {left, mid, right}, 1 = black line
//   mode     : motor command (00 stop, 01 left, 10 right, 11 straight)
//   lost     : high while searching for a lost line
//   state    : FSM state encoding for LEDs/debug
module track_ctrl #(
   parameter int DEB_CYCLES  = 100_000,
   parameter int LOST_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] sensor,
   output logic [1:0] mode,
   output logic       lost,
   output logic [2:0] state
);
   import track_pkg::*;

   localparam int LW = $clog2(LOST_CYCLES + 1);
   localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);

   logic [2:0]    filt;
   pat_t          pat;
   state_t        state_q, state_nxt;
   state_t        last_dir, last_dir_nxt;
   logic [LW-1:0] lost_cnt, lost_cnt_nxt;

   sensor_debounce #(
      .WIDTH      (3),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .din  (sensor),
      .filt (filt)
   );

   assign pat = decode_pat(filt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= STOP;
         last_dir <= FWD;
         lost_cnt <= '0;
      end else begin
         state_q  <= state_nxt;
         last_dir <= last_dir_nxt;
         lost_cnt <= lost_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      last_dir_nxt = last_dir;
      lost_cnt_nxt = lost_cnt;
      if (!en) begin
         state_nxt = STOP;
      end else begin
         case (state_q)
            STOP: begin
               if (pat.hit) state_nxt = pat.dir;
            end
            FWD, LEFT, RIGHT: begin
               if (pat.hit) begin
                  state_nxt = pat.dir;
               end else if (pat.none) begin
                  state_nxt    = LOST;
                  last_dir_nxt = state_q;
                  lost_cnt_nxt = '0;
               end
            end
            LOST: begin
               // A reacquired line takes priority over the timeout.
               if (pat.hit)
                  state_nxt = pat.dir;
               else if (pat.none) begin
                  if (lost_cnt == LOST_LAST)
                     state_nxt = STOP;
                  else
                     lost_cnt_nxt = lost_cnt + LW'(1);
               end
            end
            default: state_nxt = STOP;
         endcase
      end
   end

   // While lost, keep steering the way we were last heading.
   assign mode  = mode_of((state_q == LOST) ? last_dir : state_q);
   assign lost  = (state_q == LOST);
   assign state = state_q;

endmodule
